// File: rtl/rx_word_arbiter.sv
// rx_word_arbiter: shares one valid/ready word port between four receiver
// channels. One holding register per channel, round-robin grant starting
// after the last granted channel, sticky per-channel overflow flags.
// Optional link watchdog compiled in with `define RX_ARB_WATCHDOG_EN;
// without it link_ok is tied high.
//
// state  | meaning
// IDLE   | nothing offered, waiting for any full holder
// OFFER  | out_data/out_ch offered with out_valid=1 until accepted

module rx_word_arbiter #(
    parameter int                 DW       = 36,
    parameter int                 TO_BITS  = 16,
    parameter logic [TO_BITS-1:0] TO_LIMIT = 16'hFFFF
) (
    input  logic            clk,
    input  logic            res,
    input  logic [4*DW-1:0] in_data,
    input  logic [3:0]      in_valid,
    input  logic [3:0]      ch_en,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      ovf,
    input  logic            ovf_clr,
    output logic [3:0]      link_ok
);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    state_t          state, state_nx;
    logic [1:0]      ptr;
    logic [DW-1:0]   hold_data [4];
    logic [3:0]      hold_full;
    logic [3:0]      take;
    logic [3:0]      gnt_vec;
    logic [3:0]      ovf_set;
    logic            gnt_any;
    logic [1:0]      gnt_ch;
    logic            do_grant;

    assign take      = in_valid & ch_en;
    assign out_valid = (state == S_OFFER);

    // Round-robin search: first full holder starting at ptr+1, ptr itself last.
    always_comb begin
        logic [1:0] idx;
        gnt_any = 1'b0;
        gnt_ch  = ptr;
        idx     = ptr;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!gnt_any && hold_full[idx]) begin
                gnt_any = 1'b1;
                gnt_ch  = idx;
            end
        end
    end

    // Next-state logic; a grant is taken from IDLE or on accept in OFFER.
    always_comb begin
        state_nx = state;
        do_grant = 1'b0;
        case (state)
            S_IDLE: begin
                if (gnt_any) begin
                    do_grant = 1'b1;
                    state_nx = S_OFFER;
                end
            end
            S_OFFER: begin
                if (out_ready) begin
                    if (gnt_any) begin
                        do_grant = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign gnt_vec = do_grant ? (4'b0001 << gnt_ch) : 4'b0000;
    // A holder being granted this cycle can take a new word without overflow.
    assign ovf_set = take & hold_full & ~gnt_vec;

    // State register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Output word register and round-robin pointer, updated on every grant.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            out_data <= '0;
            out_ch   <= 2'd0;
            ptr      <= 2'd3;
        end else if (do_grant) begin
            out_data <= hold_data[gnt_ch];
            out_ch   <= gnt_ch;
            ptr      <= gnt_ch;
        end
    end

    // Per-channel holding registers: load when empty or being granted.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            hold_full <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                hold_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (take[k] && (!hold_full[k] || gnt_vec[k])) begin
                    hold_data[k] <= in_data[k*DW +: DW];
                    hold_full[k] <= 1'b1;
                end else if (gnt_vec[k]) begin
                    hold_full[k] <= 1'b0;
                end
            end
        end
    end

    // Sticky overflow; a new overflow survives a simultaneous clear.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ovf <= 4'b0000;
        end else if (ovf_clr) begin
            ovf <= ovf_set;
        end else begin
            ovf <= ovf | ovf_set;
        end
    end

`ifdef RX_ARB_WATCHDOG_EN
    logic [TO_BITS-1:0] wd_cnt [4];
    logic [3:0]         seen;

    // Idle counters per channel; seen marks that a word has arrived since
    // enable so that link_ok stays low until real traffic is observed.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            seen <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                wd_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!ch_en[k]) begin
                    wd_cnt[k] <= '0;
                    seen[k]   <= 1'b0;
                end else if (in_valid[k]) begin
                    wd_cnt[k] <= '0;
                    seen[k]   <= 1'b1;
                end else if (wd_cnt[k] != TO_LIMIT) begin
                    wd_cnt[k] <= wd_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Link is healthy while enabled, seen and not yet timed out.
    always_comb begin
        link_ok = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            link_ok[k] = seen[k] & ch_en[k] & (wd_cnt[k] != TO_LIMIT);
        end
    end
`else
    assign link_ok = 4'hF;
`endif

endmodule

// File: doc/rx_word_arbiter.md
# rx_word_arbiter

Round-robin scheduler that shares one downstream word port between four serial receiver channels. Each channel delivers 36-bit words as single-cycle valid pulses. The block holds one word per channel, grants channels in round-robin order onto a valid/ready output tagged with the channel number, and flags overflow per channel. An optional link watchdog reports per-channel link health. Inputs are synchronous to `clk`; clock-domain crossing from the receiver clocks is done upstream.

## Interface
- `DW`, 36, word width.
- `TO_BITS`, 16, watchdog counter width.
- `TO_LIMIT`, 16'hFFFF, idle cycles before a link is declared lost.

- `clk`  in  1  system clock, all logic on rising edge.
- `res`  in  1  reset, asynchronous, active-high.
- `in_data`  in  4*DW  channel words; ch k at `[k*DW +: DW]`.
- `in_valid`  in  4  one-cycle word strobe per channel.
- `ch_en`  in  4  channel enable; a disabled channel's `in_valid` is ignored.
- `out_data`  out  DW  granted word.
- `out_ch`  out  2  channel number of `out_data`.
- `out_valid`  out  1  word offered.
- `out_ready`  in  1  downstream accepts.
- `ovf`  out  4  sticky per-channel overflow.
- `ovf_clr`  in  1  clears all `ovf` bits.
- `link_ok`  out  4  per-channel link health; see Configuration.

## Operation
- Per channel: holding register `hold_data[k]` and `hold_full[k]`.
- Load: `in_valid[k] & ch_en[k]` loads the word and sets `hold_full[k]`, provided the holder is empty or is being granted in the same cycle.
- Overflow: `in_valid[k] & ch_en[k]` while the holder is full and not granted this cycle. The new word is dropped, the held word is kept, and `ovf[k]` is set.
- `ovf` set takes priority over `ovf_clr` in the same cycle.
- Disabling a channel does not discard its held word; that word is still granted.
- Arbiter FSM, two states:
  - IDLE: `out_valid=0`. If any `hold_full`, grant the first full channel searching from `ptr+1` modulo 4. On grant:
    - copy the word into `out_data`/`out_ch`;
    - clear that `hold_full`;
    - set `ptr` to the granted channel;
    - go to OFFER.
  - OFFER: `out_valid=1`; `out_data` and `out_ch` stay stable until `out_valid & out_ready`. On accept:
    - if any `hold_full`, grant the next channel in the same cycle and stay in OFFER (back-to-back, no bubble);
    - otherwise go to IDLE.
- Simultaneous grant and new word on the same channel: the granted word goes out, the new word fills the holder, no overflow.
- Reset values: state IDLE, `out_valid=0`, `out_data=0`, `out_ch=0`, `hold_full=0`, `ovf=0`, `ptr=3` (ch0 wins first), `link_ok=0` when the watchdog is compiled in.

## Timing
- `in_valid` at cycle n gives `hold_full` at n+1 and `out_valid` at n+2 when the FSM is IDLE. Minimum latency is 2 cycles.
- Sustained throughput is one word per cycle while `out_ready=1` and words are pending.
- `ovf[k]` asserts the cycle after the dropped strobe.
- `res` asserted mid-transfer clears everything immediately; any offered word is lost.

## Configuration
- `RX_ARB_WATCHDOG_EN` defined:
  - one `TO_BITS` counter per channel, cleared on an accepted `in_valid[k]`, otherwise incremented, saturating at `TO_LIMIT`;
  - `link_ok[k]=1` from the cycle after the first accepted word until the counter reaches `TO_LIMIT`;
  - `link_ok[k]` is then 0 until the next accepted word;
  - a disabled channel holds its counter at 0 and drives `link_ok[k]=0`.
- `RX_ARB_WATCHDOG_EN` undefined: no counters; `link_ok` is tied to 4'hF.

## Test plan
- Single word: ch2 `in_valid` with 36'h123456789 and `out_ready=1` -> `out_valid` 2 cycles later, `out_data`=36'h123456789, `out_ch`=2, one cycle wide.
- Round-robin: all four channels strobe in the same cycle, `out_ready=1` -> grants ch0, ch1, ch2, ch3 on consecutive cycles. Then repeat after ch1 was last granted -> order ch2, ch3, ch0, ch1.
- Backpressure: `out_ready=0` for 10 cycles with ch0 offered -> `out_data`/`out_ch` stable. A second ch0 strobe fills the holder; a third sets `ovf[0]`, and the first word is the one delivered.
- Same-cycle refill: ch1 granted in the same cycle as a new ch1 strobe -> no `ovf`, and the second word is delivered next.
- Overflow clear: `ovf_clr` and an overflow event in the same cycle -> `ovf` stays set; `ovf_clr` alone -> 4'h0.
- Watchdog (macro on, `TO_LIMIT`=16): ch3 enabled, one strobe then silence -> `link_ok[3]` is 1 until the counter reaches 16 and then drops; the next strobe restores it. Async `res` mid-offer -> all outputs return to reset values immediately.
